// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port byte/half/word data memory with registered response
//
// Purpose: data memory for the LSU load/store path. A request is accepted on a
// valid/ready handshake, checked for size/alignment/range errors, and answered
// through a one-entry response register. Stores update only the addressed byte
// lanes. Loads are shifted down to the addressed lane and sign- or zero-extended.
// Illegal requests return resp_err = 1 and never write memory.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   req_valid      request present
//   req_ready      request can be accepted this cycle (combinational from resp_ready)
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned   loads: 1 = zero-extend, 0 = sign-extend
//   req_addr       byte address
//   req_wdata      store data, low bits used for byte/half
//   resp_valid     response present
//   resp_ready     consumer takes the response
//   resp_rdata     extended load data; 0 for stores and errors
//   resp_err       request was illegal

module data_ram #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'(4) << DEPTH_LOG2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  err;
  logic                  accept;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] wrep;
  logic [DATA_WIDTH-1:0] rword;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;

  // An address below BASE_ADDR wraps to a huge offset, so one unsigned
  // compare covers both ends of the window.
  assign offset = req_addr - BASE_ADDR;
  assign idx    = offset[DEPTH_LOG2+1:2];
  assign lane   = req_addr[1:0];

  always_comb begin
    err = 1'b0;
    if (req_size == 2'b11)                         err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])        err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 0) err = 1'b1;
    if (offset >= SPAN)                            err = 1'b1;
  end

  assign req_ready = !resp_valid || resp_ready;
  // A request seen during reset is never taken, even if req_ready is high.
  assign accept    = req_valid && req_ready && !rst;

  // Store data is replicated across lanes so the byte enables alone pick
  // which bytes land.
  always_comb begin
    byte_en = 4'b0000;
    wrep    = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wrep    = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wrep    = req_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wrep    = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign rword   = mem[idx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    load_data = shifted;
    case (req_size)
      SZ_BYTE: load_data = {{24{!req_unsigned && shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{!req_unsigned && shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= err;
      resp_rdata <= (!req_write && !err) ? load_data : '0;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
